maze_player_render: RTL and testbench

//  Pixel source feeding vga_sync (iRed/iGreen/iBlue) from its px/py coordinates. Holds a

---
 rtl/maze_player_render.sv | 219 +++++++++++++++++++++
 tb/tb_maze_player_render.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/maze_player_render.sv
`default_nettype none
// ============================================================================
// Module      : maze_player_render
// Description : Tile-maze pixel source for vga_sync. Moves one player token
//               through a walled maze under direction inputs (rate limited to
//               one step per MOVE_FRAMES frames), detects arrival at the goal
//               and paints walls, floor, goal and player with 1-cycle latency.
// Revision    : 1.0 - initial release
// ============================================================================
module maze_player_render #(
    parameter int TILE_LOG2   = 5,
    parameter int COLS        = 20,
    parameter int ROWS        = 15,
    parameter int MOVE_FRAMES = 8,
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480
) (
    input  logic       iCLK,
    input  logic       iRST_N,
    input  logic [9:0] px,
    input  logic [9:0] py,
    input  logic       iUp,
    input  logic       iDown,
    input  logic       iLeft,
    input  logic       iRight,
    output logic [9:0] oRed,
    output logic [9:0] oGreen,
    output logic [9:0] oBlue,
    output logic [4:0] oPlayerX,
    output logic [3:0] oPlayerY,
    output logic       oWin
);

    // Step-rate counter only has to reach MOVE_FRAMES-1.
    localparam int            c_CNT_W    = (MOVE_FRAMES > 1) ? $clog2(MOVE_FRAMES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(MOVE_FRAMES - 1);

    localparam logic [9:0] c_COL_LAST = 10'(COLS - 1);
    localparam logic [9:0] c_ROW_LAST = 10'(ROWS - 1);
    localparam logic [4:0] c_GOAL_X   = 5'(COLS - 2);
    localparam logic [3:0] c_GOAL_Y   = 4'(ROWS - 2);
    localparam logic [9:0] c_H_END    = 10'(H_ACTIVE);
    localparam logic [9:0] c_V_END    = 10'(V_ACTIVE);

    localparam logic [29:0] c_RGB_BLACK  = {10'h000, 10'h000, 10'h000};
    localparam logic [29:0] c_RGB_YELLOW = {10'h3FF, 10'h3FF, 10'h000};
    localparam logic [29:0] c_RGB_GREEN  = {10'h000, 10'h3FF, 10'h000};
    localparam logic [29:0] c_RGB_BLUE   = {10'h000, 10'h000, 10'h3FF};
    localparam logic [29:0] c_RGB_GREY   = {10'h080, 10'h080, 10'h080};

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_CHECK = 2'd1;
    localparam logic [1:0] c_ST_MOVE  = 2'd2;
    localparam logic [1:0] c_ST_WON   = 2'd3;

    localparam logic [1:0] c_DIR_UP    = 2'd0;
    localparam logic [1:0] c_DIR_DOWN  = 2'd1;
    localparam logic [1:0] c_DIR_LEFT  = 2'd2;
    localparam logic [1:0] c_DIR_RIGHT = 2'd3;

    // Border ring plus the even/even pillar lattice are walls.
    function automatic logic f_is_wall(input logic [9:0] tx, input logic [9:0] ty);
        return (tx == 10'd0) || (tx == c_COL_LAST) ||
               (ty == 10'd0) || (ty == c_ROW_LAST) ||
               (!tx[0] && !ty[0]);
    endfunction

    logic [1:0]         r_state;
    logic [c_CNT_W-1:0] r_step_cnt;
    logic [1:0]         r_dir;
    logic [4:0]         r_pos_x;
    logic [3:0]         r_pos_y;
    logic [4:0]         r_tgt_x;
    logic [3:0]         r_tgt_y;
    logic               r_win;
    logic [9:0]         r_prev_py;
    logic [4:0]         r_flash;
    logic [29:0]        r_rgb;

    logic [9:0]  w_tx;
    logic [9:0]  w_ty;
    logic        w_tick;
    logic        w_any_dir;
    logic [1:0]  w_dir;
    logic [4:0]  w_tgt_x;
    logic [3:0]  w_tgt_y;
    logic        w_tgt_wall;
    logic        w_on_player;
    logic        w_on_goal;
    logic        w_visible;
    logic [29:0] w_rgb;

    assign w_tx        = px >> TILE_LOG2;
    assign w_ty        = py >> TILE_LOG2;
    assign w_tick      = (py == 10'd0) && (r_prev_py != 10'd0);
    assign w_any_dir   = iUp | iDown | iLeft | iRight;
    assign w_on_player = (w_tx == {5'd0, r_pos_x}) && (w_ty == {6'd0, r_pos_y});
    assign w_on_goal   = (w_tx == {5'd0, c_GOAL_X}) && (w_ty == {6'd0, c_GOAL_Y});
    assign w_visible   = (px < c_H_END) && (py < c_V_END);
    assign w_tgt_wall  = f_is_wall({5'd0, w_tgt_x}, {6'd0, w_tgt_y});

    // Fixed priority Up > Down > Left > Right; only the winner is used.
    always_comb begin
        w_dir = c_DIR_RIGHT;
        if (iUp)        w_dir = c_DIR_UP;
        else if (iDown) w_dir = c_DIR_DOWN;
        else if (iLeft) w_dir = c_DIR_LEFT;
    end

    // Neighbouring tile in the latched direction; the wall border keeps it on-grid.
    always_comb begin
        w_tgt_x = r_pos_x;
        w_tgt_y = r_pos_y;
        case (r_dir)
            c_DIR_UP:    w_tgt_y = r_pos_y - 4'd1;
            c_DIR_DOWN:  w_tgt_y = r_pos_y + 4'd1;
            c_DIR_LEFT:  w_tgt_x = r_pos_x - 5'd1;
            default:     w_tgt_x = r_pos_x + 5'd1;
        endcase
    end

    // Previous-line tracker for the frame tick and the free-running flash counter.
    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            r_prev_py <= 10'd0;
            r_flash   <= 5'd0;
        end else begin
            r_prev_py <= py;
            if (w_tick) r_flash <= r_flash + 5'd1;
        end
    end

    // Movement FSM: rate-limit, wall check, commit, terminal win.
    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            r_state    <= c_ST_IDLE;
            r_step_cnt <= '0;
            r_dir      <= c_DIR_UP;
            r_pos_x    <= 5'd1;
            r_pos_y    <= 4'd1;
            r_tgt_x    <= 5'd1;
            r_tgt_y    <= 4'd1;
            r_win      <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (!w_any_dir) begin
                        r_step_cnt <= '0;
                    end else if (w_tick) begin
                        if (r_step_cnt == c_CNT_LAST) begin
                            r_step_cnt <= '0;
                            r_dir      <= w_dir;
                            r_state    <= c_ST_CHECK;
                        end else begin
                            r_step_cnt <= r_step_cnt + c_CNT_W'(1);
                        end
                    end
                end
                c_ST_CHECK: begin
                    if (w_tgt_wall) begin
                        r_state <= c_ST_IDLE;
                    end else begin
                        r_tgt_x <= w_tgt_x;
                        r_tgt_y <= w_tgt_y;
                        r_state <= c_ST_MOVE;
                    end
                end
                c_ST_MOVE: begin
                    r_pos_x <= r_tgt_x;
                    r_pos_y <= r_tgt_y;
                    if ((r_tgt_x == c_GOAL_X) && (r_tgt_y == c_GOAL_Y)) begin
                        r_win   <= 1'b1;
                        r_state <= c_ST_WON;
                    end else begin
                        r_state <= c_ST_IDLE;
                    end
                end
                c_ST_WON: begin
                    r_win <= 1'b1;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    // Pixel colour by priority. After the win the player sits on the goal, so
    // that tile blinks green/black instead of showing the player colour.
    always_comb begin
        w_rgb = c_RGB_GREY;
        if (!w_visible) begin
            w_rgb = c_RGB_BLACK;
        end else if ((r_state == c_ST_WON) && w_on_goal) begin
            w_rgb = r_flash[4] ? c_RGB_BLACK : c_RGB_GREEN;
        end else if (w_on_player) begin
            w_rgb = c_RGB_YELLOW;
        end else if (w_on_goal) begin
            w_rgb = c_RGB_GREEN;
        end else if (f_is_wall(w_tx, w_ty)) begin
            w_rgb = c_RGB_BLUE;
        end
    end

    // One-cycle registered colour output.
    always_ff @(posedge iCLK) begin
        if (!iRST_N) r_rgb <= c_RGB_BLACK;
        else         r_rgb <= w_rgb;
    end

    assign oRed     = r_rgb[29:20];
    assign oGreen   = r_rgb[19:10];
    assign oBlue    = r_rgb[9:0];
    assign oPlayerX = r_pos_x;
    assign oPlayerY = r_pos_y;
    assign oWin     = r_win;

endmodule
`default_nettype wire

// File: tb/tb_maze_player_render.sv
`default_nettype none
// ============================================================================
// Module      : tb_maze_player_render
// Description : Self-checking bench for maze_player_render with a tile-level
//               reference model and randomized pixel/direction stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_maze_player_render;

    localparam int MF = 2;
    localparam logic [29:0] YELLOW = {10'h3FF, 10'h3FF, 10'h000};
    localparam logic [29:0] GREEN  = {10'h000, 10'h3FF, 10'h000};
    localparam logic [29:0] BLUE   = {10'h000, 10'h000, 10'h3FF};
    localparam logic [29:0] GREY   = {10'h080, 10'h080, 10'h080};

    logic       iCLK = 1'b0;
    logic       iRST_N;
    logic [9:0] px, py;
    logic       iUp, iDown, iLeft, iRight;
    logic [9:0] oRed, oGreen, oBlue;
    logic [4:0] oPlayerX;
    logic [3:0] oPlayerY;
    logic       oWin;

    int checks = 0;
    int errors = 0;
    int n_ticks = 0;

    // Reference model state (tile coordinates, plain integers)
    int          m_x, m_y, m_cnt, m_busy, m_tx, m_ty, m_flash, m_prev_py;
    bit          m_won, m_commit, m_tick;
    bit          m_valid = 1'b0;
    logic [29:0] m_rgb;

    maze_player_render #(.MOVE_FRAMES(MF)) dut (
        .iCLK(iCLK), .iRST_N(iRST_N), .px(px), .py(py),
        .iUp(iUp), .iDown(iDown), .iLeft(iLeft), .iRight(iRight),
        .oRed(oRed), .oGreen(oGreen), .oBlue(oBlue),
        .oPlayerX(oPlayerX), .oPlayerY(oPlayerY), .oWin(oWin)
    );

    always #5 iCLK = ~iCLK;

    function automatic bit is_wall(int tx, int ty);
        return tx == 0 || tx == 19 || ty == 0 || ty == 14 || (tx % 2 == 0 && ty % 2 == 0);
    endfunction

    function automatic logic [29:0] colour(int x, int y, int pxp, int pyp, bit won, int flash);
        int tx, ty;
        bit goal;
        if (x >= 640 || y >= 480) return 30'd0;
        tx = x / 32;
        ty = y / 32;
        goal = (tx == 18 && ty == 13);
        if (won && goal) return ((flash / 16) % 2 == 1) ? 30'd0 : GREEN;
        if (tx == pxp && ty == pyp) return YELLOW;
        if (goal) return GREEN;
        if (is_wall(tx, ty)) return BLUE;
        return GREY;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one update per clock from the sampled inputs
    always @(posedge iCLK) begin
        if (!iRST_N) begin
            m_x = 1; m_y = 1; m_cnt = 0; m_busy = 0; m_won = 0; m_commit = 0;
            m_prev_py = 0; m_flash = 0; m_rgb = 30'd0; m_valid = 1'b1;
        end else begin
            m_rgb  = colour(int'(px), int'(py), m_x, m_y, m_won, m_flash);
            m_tick = (py == 10'd0) && (m_prev_py != 0);
            if (m_busy > 0) begin
                m_busy--;
                if (m_busy == 0 && m_commit) begin
                    m_x = m_tx;
                    m_y = m_ty;
                    if (m_x == 18 && m_y == 13) m_won = 1;
                end
            end else if (!m_won) begin
                if (!(iUp || iDown || iLeft || iRight)) begin
                    m_cnt = 0;
                end else if (m_tick) begin
                    if (m_cnt == MF - 1) begin
                        m_cnt = 0;
                        m_tx = m_x;
                        m_ty = m_y;
                        if (iUp)        m_ty = m_y - 1;
                        else if (iDown) m_ty = m_y + 1;
                        else if (iLeft) m_tx = m_x - 1;
                        else            m_tx = m_x + 1;
                        m_commit = !is_wall(m_tx, m_ty);
                        m_busy   = m_commit ? 2 : 1;
                    end else begin
                        m_cnt++;
                    end
                end
            end
            m_prev_py = int'(py);
            if (m_tick) m_flash = (m_flash + 1) % 32;
        end
    end

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge iCLK) begin
        if (m_valid) begin
            check("rgb", {2'b0, oRed, oGreen, oBlue}, {2'b0, m_rgb});
            check("player_x", {27'd0, oPlayerX}, m_x);
            check("player_y", {28'd0, oPlayerY}, m_y);
            check("win", {31'd0, oWin}, {31'd0, m_won});
        end
    end

    task automatic cyc();
        @(posedge iCLK);
        #1;
    endtask

    task automatic set_dir(bit u, bit d, bit l, bit r);
        iUp = u; iDown = d; iLeft = l; iRight = r;
    endtask

    // Cycles with a non-zero line, often aimed at the player or goal tile
    task automatic idle(int n);
        for (int i = 0; i < n; i++) begin
            case ($urandom_range(0, 5))
                0: begin px = 10'(m_x * 32 + $urandom_range(0, 31)); py = 10'(m_y * 32 + $urandom_range(0, 31)); end
                1: begin px = 10'(18 * 32 + $urandom_range(0, 31));  py = 10'(13 * 32 + $urandom_range(0, 31)); end
                default: begin px = 10'($urandom_range(0, 799)); py = 10'($urandom_range(1, 519)); end
            endcase
            cyc();
        end
    endtask

    // One frame: non-zero lines followed by line 0, which gives one tick
    task automatic frame(int len);
        idle(len - 1);
        px = 10'($urandom_range(0, 799));
        py = 10'd0;
        cyc();
        n_ticks++;
    endtask

    task automatic move(bit u, bit d, bit l, bit r);
        set_dir(u, d, l, r);
        frame(6);
        frame(6);
        set_dir(0, 0, 0, 0);
        idle(3);
    endtask

    initial begin
        iRST_N = 1'b0;
        set_dir(0, 0, 0, 0);
        px = 10'd40;
        py = 10'd40;
        // Reset state
        cyc();
        cyc();
        check("reset_x", {27'd0, oPlayerX}, 1);
        check("reset_y", {28'd0, oPlayerY}, 1);
        check("reset_win", {31'd0, oWin}, 0);
        check("reset_rgb", {2'b0, oRed, oGreen, oBlue}, 0);
        check("model_reset_x", m_x, 1);
        iRST_N = 1'b1;
        n_ticks = 0;
        @(negedge iCLK);
        check("release_rgb", {2'b0, oRed, oGreen, oBlue}, 0);

        // Colour literals around the start position
        px = 10'd40;  py = 10'd40;  cyc();
        check("rgb_player", {2'b0, oRed, oGreen, oBlue}, {2'b0, YELLOW});
        check("model_rgb_player", {2'b0, m_rgb}, {2'b0, YELLOW});
        px = 10'd0;   py = 10'd100; cyc();
        check("rgb_wall", {2'b0, oRed, oGreen, oBlue}, {2'b0, BLUE});
        px = 10'd700; py = 10'd100; cyc();
        check("rgb_offscreen", {2'b0, oRed, oGreen, oBlue}, 0);
        px = 10'd80;  py = 10'd40;  cyc();
        check("rgb_floor", {2'b0, oRed, oGreen, oBlue}, {2'b0, GREY});
        check("model_rgb_floor", {2'b0, m_rgb}, {2'b0, GREY});
        px = 10'd579; py = 10'd419; cyc();
        check("rgb_goal", {2'b0, oRed, oGreen, oBlue}, {2'b0, GREEN});

        // Step right after MF ticks, committed two cycles after the tick
        set_dir(0, 0, 0, 1);
        frame(6);
        frame(6);
        idle(1);
        check("step_x_t1", {27'd0, oPlayerX}, 1);
        idle(1);
        check("step_x_t2", {27'd0, oPlayerX}, 2);
        check("step_y_t2", {28'd0, oPlayerY}, 1);
        check("model_step_x", m_x, 2);
        set_dir(0, 0, 0, 0);
        idle(3);

        // Wall collision, then Up beating Right into a wall
        set_dir(0, 1, 0, 0);
        repeat (4) frame(6);
        idle(3);
        check("wall_down_x", {27'd0, oPlayerX}, 2);
        check("wall_down_y", {28'd0, oPlayerY}, 1);
        set_dir(1, 0, 0, 1);
        repeat (2) frame(6);
        idle(3);
        check("prio_up_x", {27'd0, oPlayerX}, 2);
        check("prio_up_y", {28'd0, oPlayerY}, 1);
        set_dir(0, 0, 0, 0);
        idle(3);

        // Randomized wandering
        for (int f = 0; f < 80; f++) begin
            if ($urandom_range(0, 3) == 0) set_dir(0, 0, 0, 0);
            else begin
                logic [3:0] d;
                d = 4'($urandom_range(0, 15));
                set_dir(d[3], d[2], d[1], d[0]);
            end
            frame($urandom_range(4, 10));
        end
        set_dir(0, 0, 0, 0);
        idle(3);

        // Reset while the FSM is checking a step
        set_dir(0, 0, 0, 1);
        frame(6);
        frame(6);
        iRST_N = 1'b0;
        cyc();
        iRST_N = 1'b1;
        n_ticks = 0;
        check("rst_check_x", {27'd0, oPlayerX}, 1);
        check("rst_check_y", {28'd0, oPlayerY}, 1);
        check("rst_check_win", {31'd0, oWin}, 0);
        frame(6);
        idle(3);
        check("rst_cnt_cleared_x", {27'd0, oPlayerX}, 1);
        set_dir(0, 0, 0, 0);
        idle(3);

        // Scripted path to the goal: right along row 1, down column 17
        repeat (16) move(0, 0, 0, 1);
        repeat (12) move(0, 1, 0, 0);
        check("path_x", {27'd0, oPlayerX}, 17);
        check("path_y", {28'd0, oPlayerY}, 13);
        set_dir(0, 0, 0, 1);
        frame(6);
        frame(6);
        idle(1);
        check("win_before_move", {31'd0, oWin}, 0);
        idle(1);
        check("win_in_move", {31'd0, oWin}, 1);
        check("win_x", {27'd0, oPlayerX}, 18);
        check("win_y", {28'd0, oPlayerY}, 13);

        // Inputs ignored after winning
        for (int f = 0; f < 8; f++) begin
            logic [3:0] d;
            d = 4'($urandom_range(1, 15));
            set_dir(d[3], d[2], d[1], d[0]);
            frame(6);
        end
        set_dir(0, 0, 0, 0);
        idle(3);
        check("won_x_frozen", {27'd0, oPlayerX}, 18);
        check("won_y_frozen", {28'd0, oPlayerY}, 13);

        // Goal blink: green while tick count bit4 is 0, black while it is 1
        while ((n_ticks % 32) >= 16) frame(5);
        px = 10'd590; py = 10'd430; cyc();
        check("blink_green", {2'b0, oRed, oGreen, oBlue}, {2'b0, GREEN});
        repeat (16) frame(5);
        px = 10'd590; py = 10'd430; cyc();
        check("blink_black", {2'b0, oRed, oGreen, oBlue}, 0);
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
